bcnn_conv_binarize_mc: RTL and testbench

Streaming multi-channel binary convolution with per-channel threshold binarization. It generalises the single-filter 3x3 conv and binarizer pair to an arbitrary kernel size and NUM_OUT_CH parallel filters, adding valid/ready backpressure, output coordinates and frame sequencing. It sits between the binary pixel source and the next BCNN layer, and emits one NUM_OUT_CH-bit feature vector per valid window position.

---
 rtl/bcnn_pkg.sv | 33 +++
 rtl/bcnn_line_window.sv | 81 ++++++++
 rtl/bcnn_conv_binarize_mc.sv | 170 +++++++++++++++++
 tb/tb_bcnn_conv_binarize_mc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcnn_pkg.sv
// Shared types and helpers for the streaming binary convolution block:
// FSM state encoding, window bit indexing and the window popcount.
package bcnn_pkg;

  localparam int unsigned MAX_WIN_BITS = 64;
  localparam int unsigned POP_WIDTH    = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  // Flat bit position of window row r (0 = oldest), column j (0 = leftmost).
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned j,
                                          input int unsigned k);
    return r * k + j;
  endfunction

  // Count of set bits in a zero-extended window-sized vector.
  function automatic logic [POP_WIDTH-1:0] popcount(input logic [MAX_WIN_BITS-1:0] v);
    logic [POP_WIDTH-1:0]    n;
    logic [MAX_WIN_BITS-1:0] s;
    n = '0;
    s = v;
    for (int i = 0; i < int'(MAX_WIN_BITS); i++) begin
      n = n + POP_WIDTH'(s[0]);
      s = s >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcnn_line_window.sv
// Raster pixel counters, K-1 line buffers and the KxK sliding window.
// Window and counters move only on an accepted pixel; the valid/coordinate tag moves with the pipeline.
module bcnn_line_window
  import bcnn_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 28,
  parameter int unsigned IMG_HEIGHT  = 28,
  parameter int unsigned KERNEL_SIZE = 3,
  localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned RW = $clog2(IMG_HEIGHT),
  localparam int unsigned CW = $clog2(IMG_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel,
  input  logic          accept,
  input  logic          advance,
  output logic [KK-1:0] window,
  output logic          window_valid,
  output logic [RW-1:0] window_row,
  output logic [CW-1:0] window_col,
  output logic          window_last,
  output logic          last_pixel_c
);

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [KERNEL_SIZE-1:0] col_vec;
  logic [KK-1:0]          window_next;
  logic                   at_window_c;

  // Column entering the window: oldest line first, live pixel last.
  assign col_vec[KERNEL_SIZE-1] = pixel;

  for (genvar i = 0; i < KERNEL_SIZE - 1; i++) begin : g_line
    logic [IMG_WIDTH-1:0] line;
    assign col_vec[i] = line[col];
    always_ff @(posedge clk) begin
      if (accept) line[col] <= col_vec[i+1];
    end
  end

  for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_win
    assign window_next[win_idx(r, 0, KERNEL_SIZE) +: KERNEL_SIZE] =
      {col_vec[r], window[win_idx(r, 1, KERNEL_SIZE) +: KERNEL_SIZE-1]};
  end

  assign last_pixel_c = (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));
  assign at_window_c  = (row >= RW'(KERNEL_SIZE - 1)) && (col >= CW'(KERNEL_SIZE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      window       <= '0;
      window_valid <= 1'b0;
      window_row   <= '0;
      window_col   <= '0;
      window_last  <= 1'b0;
    end else begin
      if (accept) begin
        window <= window_next;
        if (col == CW'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (advance) begin
        window_valid <= accept && at_window_c;
        if (accept) begin
          window_row  <= row - RW'(KERNEL_SIZE - 1);
          window_col  <= col - CW'(KERNEL_SIZE - 1);
          window_last <= last_pixel_c;
        end
      end
    end
  end

endmodule

// File: rtl/bcnn_conv_binarize_mc.sv
// Multi-channel streaming binary convolution with per-channel threshold binarization.
// Define BCNN_POPCOUNT_OUT_EN to expose the registered raw popcounts on out_sums.
module bcnn_conv_binarize_mc
  import bcnn_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = 28,
  parameter int unsigned IMG_HEIGHT  = 28,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned NUM_OUT_CH  = 4,
  parameter int unsigned SUM_WIDTH   = 4,
  localparam int unsigned KK = KERNEL_SIZE * KERNEL_SIZE,
  localparam int unsigned RW = $clog2(IMG_HEIGHT),
  localparam int unsigned CW = $clog2(IMG_WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pixel_in,
  input  logic                          valid_in,
  output logic                          in_ready,
  input  logic [NUM_OUT_CH*KK-1:0]      weight_bits,
  input  logic [NUM_OUT_CH*SUM_WIDTH-1:0] thresholds,
  output logic [NUM_OUT_CH-1:0]         out_bits,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RW-1:0]                 out_row,
  output logic [CW-1:0]                 out_col,
  output logic                          out_last,
  output logic                          frame_done
`ifdef BCNN_POPCOUNT_OUT_EN
  ,
  output logic [NUM_OUT_CH*SUM_WIDTH-1:0] out_sums
`endif
);

  state_t state, state_d;
  logic   done_d;
  logic   advance;
  logic   accept;

  logic [KK-1:0] w_window;
  logic          w_valid;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_last;
  logic          last_pixel_c;

  logic [KK-1:0] s1_window;
  logic          s1_valid;
  logic [RW-1:0] s1_row;
  logic [CW-1:0] s1_col;
  logic          s1_last;

  logic [NUM_OUT_CH*KK-1:0]        shadow_w;
  logic [NUM_OUT_CH*SUM_WIDTH-1:0] shadow_t;
  logic [NUM_OUT_CH*SUM_WIDTH-1:0] lane_sum;
  logic [NUM_OUT_CH-1:0]           lane_bit;

  // Whole pipeline moves as one unit whenever the output slot can take a new vector.
  assign advance  = !out_valid || out_ready;
  assign in_ready = !reset && (state != ST_FLUSH) && advance;
  assign accept   = valid_in && in_ready;

  bcnn_line_window #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .KERNEL_SIZE(KERNEL_SIZE)
  ) u_line_window (
    .clk         (clk),
    .reset       (reset),
    .pixel       (pixel_in),
    .accept      (accept),
    .advance     (advance),
    .window      (w_window),
    .window_valid(w_valid),
    .window_row  (w_row),
    .window_col  (w_col),
    .window_last (w_last),
    .last_pixel_c(last_pixel_c)
  );

  // Filter set is frozen for the whole frame at its first accepted pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_w <= '0;
      shadow_t <= '0;
    end else if (state == ST_IDLE && accept) begin
      shadow_w <= weight_bits;
      shadow_t <= thresholds;
    end
  end

  for (genvar c = 0; c < NUM_OUT_CH; c++) begin : g_lane
    logic [KK-1:0] match;
    assign match = ~(s1_window ^ shadow_w[c*KK +: KK]);
    assign lane_sum[c*SUM_WIDTH +: SUM_WIDTH] = SUM_WIDTH'(popcount(MAX_WIN_BITS'(match)));
    assign lane_bit[c] = lane_sum[c*SUM_WIDTH +: SUM_WIDTH] >= shadow_t[c*SUM_WIDTH +: SUM_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_window <= '0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_valid  <= w_valid;
      if (w_valid) begin
        s1_window <= w_window;
        s1_row    <= w_row;
        s1_col    <= w_col;
        s1_last   <= w_last;
      end
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_bits <= lane_bit;
        out_row  <= s1_row;
        out_col  <= s1_col;
      end
    end
  end

`ifdef BCNN_POPCOUNT_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sums <= '0;
    end else if (advance && s1_valid) begin
      out_sums <= lane_sum;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      frame_done <= done_d;
    end
  end

  // FLUSH ends on the out_last handshake; that vector is the final one in the pipe.
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_d = last_pixel_c ? ST_FLUSH : ST_STREAM;
      end
      ST_STREAM: begin
        if (accept && last_pixel_c) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (out_valid && out_ready && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcnn_conv_binarize_mc.sv
// Directed frame-level bench for bcnn_conv_binarize_mc (28x28, K=3, 4 channels).
// Each table row describes a whole frame and the hand-computed vector every output must carry.
module tb_bcnn_conv_binarize_mc;

  localparam int W = 28;
  localparam int H = 28;
  localparam int NPIX = W * H;
  localparam int OW = 26;
  localparam int NOUT = 676;
  localparam int BUDGET = 8000;

  localparam logic [35:0] ONES   = {36{1'b1}};
  localparam logic [35:0] ZERO   = 36'h0;
  localparam logic [35:0] CENTER = {4{9'h010}};
  localparam logic [35:0] MIX    = {9'h007, 9'h155, 9'h000, 9'h1FF};

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_in;
  logic        valid_in;
  logic        in_ready;
  logic [35:0] weight_bits;
  logic [15:0] thresholds;
  logic [3:0]  out_bits;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic        out_last;
  logic        frame_done;
`ifdef BCNN_POPCOUNT_OUT_EN
  logic [15:0] out_sums;
`endif

  always #5 clk = ~clk;

  bcnn_conv_binarize_mc #(
    .IMG_WIDTH  (28),
    .IMG_HEIGHT (28),
    .KERNEL_SIZE(3),
    .NUM_OUT_CH (4),
    .SUM_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .weight_bits(weight_bits),
    .thresholds (thresholds),
    .out_bits   (out_bits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .frame_done (frame_done)
`ifdef BCNN_POPCOUNT_OUT_EN
    ,
    .out_sums   (out_sums)
`endif
  );

  typedef struct {
    int          pattern;     // 0 all ones, 1 all zeros, 2 single one at (5,7)
    logic [35:0] w;
    logic [35:0] w_alt;       // driven from pixel change_at onwards
    int          change_at;
    logic [15:0] thr;
    int          rmode;       // 0 out_ready always, 1 one cycle in three
    int          gaps;        // random valid_in holes
    logic [3:0]  exp_bits;
    logic [3:0]  exp_special;
    int          sp_row;
    int          sp_col;
    int          exp_sum;     // per-channel popcount, -1 unchecked
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pix(input int pattern, input int r, input int c);
    case (pattern)
      0:       return 1'b1;
      2:       return (r == 5) && (c == 7);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_frame(input vec_t v, input int abort_at);
    int acc = 0, cyc = 0, nout = 0, er = 0, ec = 0;
    int bit_err = 0, crd_err = 0, ready_err = 0, hold_err = 0, sum_err = 0;
    int done_cnt = 0, done_cyc = -1, last_cnt = 0, last_hs = -100;
    int acc58 = -1, first_v = -1;
    bit finished = 1'b0;
    logic       pv_stall = 1'b0;
    logic [3:0] pv_bits = '0;
    logic [4:0] pv_row = '0, pv_col = '0;
    logic       pv_last = 1'b0;
    logic [3:0] exp;
    weight_bits = v.w;
    thresholds  = v.thr;
    while (!finished && cyc < BUDGET) begin
      @(negedge clk);
      out_ready = (v.rmode == 0) || (cyc % 3 == 0);
      valid_in  = (acc < NPIX) && ((v.gaps == 0) || ($urandom_range(0, 3) != 0));
      pixel_in  = pix(v.pattern, acc / W, acc % W);
      if (v.change_at >= 0 && acc >= v.change_at) weight_bits = v.w_alt;
      #1;
      if (out_valid && !out_ready && in_ready) ready_err++;
      if (pv_stall && (!out_valid || out_bits != pv_bits || out_row != pv_row ||
                       out_col != pv_col || out_last != pv_last)) hold_err++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        exp = (er == v.sp_row && ec == v.sp_col) ? v.exp_special : v.exp_bits;
        if (out_bits != exp) bit_err++;
        if (int'(out_row) != er || int'(out_col) != ec) crd_err++;
`ifdef BCNN_POPCOUNT_OUT_EN
        if (v.exp_sum >= 0)
          for (int c = 0; c < 4; c++)
            if (int'(out_sums[c*4 +: 4]) != v.exp_sum) sum_err++;
`endif
        if (out_last) begin
          last_cnt++;
          if (nout == NOUT - 1 && er == 25 && ec == 25) last_hs = cyc;
        end
        nout++;
        ec++;
        if (ec == OW) begin
          ec = 0;
          er++;
        end
      end
      pv_stall = out_valid && !out_ready;
      pv_bits  = out_bits;
      pv_row   = out_row;
      pv_col   = out_col;
      pv_last  = out_last;
      if (valid_in && in_ready) begin
        if (acc == 58) acc58 = cyc;
        acc++;
      end
      cyc++;
      if (done_cnt > 0 && cyc > done_cyc + 2) finished = 1'b1;
      if (abort_at >= 0 && acc >= abort_at) finished = 1'b1;
    end
    valid_in = 1'b0;
    if (abort_at >= 0) return;
    check("frame_timeout", int'(cyc < BUDGET), 1);
    check("output_count", nout, NOUT);
    check("out_bits_errors", bit_err, 0);
    check("coord_errors", crd_err, 0);
    check("out_last_count", last_cnt, 1);
    check("out_last_at_25_25", int'(last_hs >= 0), 1);
    check("frame_done_pulses", done_cnt, 1);
    check("frame_done_delay", done_cyc - last_hs, 1);
    check("in_ready_while_stalled", ready_err, 0);
    check("hold_while_stalled", hold_err, 0);
    if (v.rmode == 0 && v.gaps == 0) check("latency_cycles", first_v - acc58, 3);
    if (v.exp_sum >= 0) check("out_sums_errors", sum_err, 0);
  endtask

  vec_t tv [8];

  initial begin
    tv[0] = '{0, ONES,   ONES,   -1,  16'h50A9, 0, 0, 4'b1101, 4'b1101, -1, -1, 9};
    tv[1] = '{1, ONES,   ONES,   -1,  16'hF910, 0, 0, 4'b0001, 4'b0001, -1, -1, 0};
    tv[2] = '{1, ZERO,   ZERO,   -1,  16'h9999, 0, 0, 4'b1111, 4'b1111, -1, -1, 9};
    tv[3] = '{2, CENTER, CENTER, -1,  16'h9999, 0, 0, 4'b0000, 4'b1111,  4,  6, -1};
    tv[4] = '{0, ONES,   ONES,   -1,  16'h50A9, 1, 1, 4'b1101, 4'b1101, -1, -1, 9};
    tv[5] = '{0, MIX,    MIX,    -1,  16'h4509, 1, 0, 4'b0111, 4'b0111, -1, -1, -1};
    tv[6] = '{0, ONES,   ZERO,   400, 16'h50A9, 0, 1, 4'b1101, 4'b1101, -1, -1, 9};
    tv[7] = '{0, ZERO,   ZERO,   -1,  16'h50A9, 0, 0, 4'b0100, 4'b0100, -1, -1, 0};

    reset       = 1'b1;
    valid_in    = 1'b0;
    pixel_in    = 1'b0;
    out_ready   = 1'b1;
    weight_bits = '0;
    thresholds  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("in_ready_during_reset", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_release", int'(in_ready), 1);
    check("outputs_after_reset",
          int'({out_valid, out_bits, out_row, out_col, out_last, frame_done}), 0);

    for (int i = 0; i < 8; i++) run_frame(tv[i], -1);

    // Abort a frame mid-stream, then require a clean frame from (0,0).
    run_frame(tv[0], 300);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_mid_frame_reset", int'(in_ready), 0);
    @(negedge clk);
    #1;
    check("outputs_after_mid_reset",
          int'({out_valid, out_bits, out_row, out_col, out_last, frame_done}), 0);
    reset = 1'b0;
    run_frame(tv[0], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
